// File: rtl/core_pkg.sv
// Shared writeback definitions: default register-file geometry, the
// writeback request record and the arbiter grant-source encoding.
package core_pkg;

    localparam int unsigned DATA_WIDTH         = 32;
    localparam int unsigned REG_MEM_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [REG_MEM_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]         data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_AUX  = 2'd2
    } wb_gnt_e;

endpackage : core_pkg

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO buffering long-latency writeback requests.
// A push is refused while full (even with a simultaneous pop); a pop on an
// empty FIFO is ignored, so a push into an empty FIFO is never popped in the
// same cycle.
module wb_skid_fifo
    import core_pkg::*;
#(
    parameter type T = wb_req_t
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  T           i_din,
    input  logic       i_pop,
    output T           o_head,
    output logic [1:0] o_count,
    output logic       o_full,
    output logic       o_empty
);

    T           r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    logic       w_push;
    logic       w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop  && (r_count != 2'd0);

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : wb_skid_fifo

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges the main pipeline writeback with a
// buffered long-latency (aux) writeback stream onto one registered write port.
// Pipeline always wins; aux requests wait in a 2-entry FIFO.
// Optional feature macro WB_ARB_STARVE_GUARD_EN: after STARVE_LIMIT
// consecutive cycles of the pipeline beating a waiting aux request, the
// pipeline is stalled for one grant so the aux head can drain.
module regfile_wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = core_pkg::DATA_WIDTH,
    parameter int unsigned REG_MEM_ADDR_WIDTH = core_pkg::REG_MEM_ADDR_WIDTH,
    parameter int unsigned STARVE_LIMIT       = 4
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pipe_valid_i,
    input  logic [REG_MEM_ADDR_WIDTH-1:0] pipe_addr_i,
    input  logic [DATA_WIDTH-1:0]         pipe_data_i,
    output logic                          pipe_ready_o,
    input  logic                          aux_valid_i,
    input  logic [REG_MEM_ADDR_WIDTH-1:0] aux_addr_i,
    input  logic [DATA_WIDTH-1:0]         aux_data_i,
    output logic                          aux_ready_o,
    output logic                          wr_en_o,
    output logic [REG_MEM_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0]         wr_data_o,
    output logic [1:0]                    aux_count_o
);

    typedef struct packed {
        logic [REG_MEM_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]         data;
    } req_t;

    req_t                          w_aux_req;
    req_t                          w_fifo_head;
    req_t                          w_sel_req;
    logic [1:0]                    w_fifo_count;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic                          w_pipe_ready;
    wb_gnt_e                       w_gnt;

    logic                          r_wr_en;
    logic [REG_MEM_ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0]         r_wr_data;

    assign w_aux_req.addr = aux_addr_i;
    assign w_aux_req.data = aux_data_i;

    wb_skid_fifo #(
        .T (req_t)
    ) u_aux_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (aux_valid_i),
        .i_din   (w_aux_req),
        .i_pop   (w_gnt == GNT_AUX),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_force;

    assign w_pipe_ready = ~r_force;

    // Count consecutive cycles a waiting aux entry loses to the pipeline;
    // arm the force flag on the cycle the count reaches STARVE_LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_force      <= 1'b0;
        end else begin
            if ((w_gnt == GNT_AUX) || w_fifo_empty) begin
                r_starve_cnt <= '0;
            end else if (w_gnt == GNT_PIPE) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
            if (w_gnt == GNT_AUX) begin
                r_force <= 1'b0;
            end else if ((w_gnt == GNT_PIPE) && !w_fifo_empty &&
                         (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1))) begin
                r_force <= 1'b1;
            end
        end
    end
`else
    logic w_unused_starve_limit;

    assign w_unused_starve_limit = ^STARVE_LIMIT;
    assign w_pipe_ready          = 1'b1;
`endif

    // Grant selection: accepted pipeline request first, then FIFO head.
    always_comb begin
        w_gnt     = GNT_NONE;
        w_sel_req = w_fifo_head;
        if (pipe_valid_i && w_pipe_ready) begin
            w_gnt          = GNT_PIPE;
            w_sel_req.addr = pipe_addr_i;
            w_sel_req.data = pipe_data_i;
        end else if (!w_fifo_empty) begin
            w_gnt = GNT_AUX;
        end
    end

    // Registered write port; a grant to register 0 is consumed without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_gnt != GNT_NONE) begin
                r_wr_en   <= (w_sel_req.addr != '0);
                r_wr_addr <= w_sel_req.addr;
                r_wr_data <= w_sel_req.data;
            end
        end
    end

    assign pipe_ready_o = w_pipe_ready;
    assign aux_ready_o  = ~w_fifo_full;
    assign aux_count_o  = w_fifo_count;
    assign wr_en_o      = r_wr_en;
    assign wr_addr_o    = r_wr_addr;
    assign wr_data_o    = r_wr_data;

endmodule : regfile_wb_arbiter
